// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: controller states and
// the width of the channel index carried on the configuration port.
package tick_scheduler_pkg;

    localparam int CH_IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_e;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: a free-running period counter that emits a one-cycle
// tick at terminal count and a square wave that toggles on each tick.
module tick_channel #(
    parameter int CNT_W = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             sync_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             running_o
);

    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             running_q, running_d;
    logic             terminal;

    assign terminal = (cnt_q == period_q - CNT_W'(1));

    // A load restarts the phase; sync and idle both hold the counter cleared.
    always_comb begin
        period_d  = period_q;
        running_d = running_q;
        cnt_d     = '0;
        tick_d    = 1'b0;
        sq_d      = 1'b0;
        if (load_i) begin
            period_d  = period_i;
            running_d = enable_i && (period_i != '0);
        end else if (!sync_i && running_q) begin
            if (terminal) begin
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                sq_d   = sq_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            period_q  <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            sq_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            sq_q      <= sq_d;
            running_q <= running_d;
        end
    end

    assign tick_o    = tick_q;
    assign sq_o      = sq_q;
    assign running_o = running_q;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: a two-state configuration controller that
// latches one write and applies it to the addressed tick_channel.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 26
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic                cfg_enable,
    input  logic                sync,
    output logic [NCH-1:0]      tick,
    output logic [NCH-1:0]      sq,
    output logic [NCH-1:0]      running
);

    state_e              state_q, state_d;
    logic [CH_IDX_W-1:0] ch_q, ch_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic                enable_q, enable_d;
    logic                apply;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            period_q <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            period_q <= period_d;
            enable_q <= enable_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        period_d  = period_q;
        enable_d  = enable_q;
        apply     = 1'b0;
        cfg_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    state_d  = ST_APPLY;
                    ch_d     = cfg_ch;
                    period_d = cfg_period;
                    enable_d = cfg_enable;
                end
            end
            ST_APPLY: begin
                apply   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Indices at or above NCH match no channel, so such writes are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .load_i    (apply && (ch_q == CH_IDX_W'(i))),
            .sync_i    (sync),
            .enable_i  (enable_q),
            .period_i  (period_q),
            .tick_o    (tick[i]),
            .sq_o      (sq[i]),
            .running_o (running[i])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: expectations go through a scoreboard
// queue and are checked against sampled outputs one cycle step at a time.
module tb_tick_scheduler;

    localparam int NCH   = 4;
    localparam int CNT_W = 26;

    logic             clock = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_enable;
    logic             sync;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   sq;
    logic [NCH-1:0]   running;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    tick_scheduler #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_enable (cfg_enable),
        .sync       (sync),
        .tick       (tick),
        .sq         (sq),
        .running    (running)
    );

    always #5 clock = ~clock;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Returns one nanosecond after the APPLY-exit edge.
    task automatic write(input logic [2:0] ch, input int period, input logic en);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_period = CNT_W'(period);
        cfg_enable = en;
        step(1);
        cfg_valid  = 1'b0;
        step(1);
    endtask

    initial begin
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_enable = 1'b0;
        sync       = 1'b0;
        step(3);

        push("rst_tick", 32'h0);    check(tick);
        push("rst_sq", 32'h0);      check(sq);
        push("rst_running", 32'h0); check(running);
        reset = 1'b0;
        step(1);
        push("rst_ready", 32'h1);   check(cfg_ready);

        // ch0 period 3: ticks at E+3, E+6, E+9, sq toggling on each
        write(3'd0, 3, 1'b1);
        push("basic_running", 32'h1); check(running[0]);
        push("basic_tick_e", 32'h0);  check(tick[0]);
        for (int k = 1; k <= 9; k++) begin
            step(1);
            push($sformatf("basic_tick_k%0d", k), (k % 3 == 0) ? 32'h1 : 32'h0);
            check(tick[0]);
            push($sformatf("basic_sq_k%0d", k), 32'((k / 3) % 2));
            check(sq[0]);
        end

        // ch1 period 1 ticks every cycle, then period 0 disables it
        write(3'd1, 1, 1'b1);
        push("p1_running", 32'h1); check(running[1]);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            push($sformatf("p1_tick_k%0d", k), 32'h1); check(tick[1]);
            push($sformatf("p1_sq_k%0d", k), 32'(k % 2)); check(sq[1]);
        end
        write(3'd1, 0, 1'b1);
        push("p0_running", 32'h0); check(running[1]);
        push("p0_tick", 32'h0);    check(tick[1]);
        step(3);
        push("p0_tick_later", 32'h0); check(tick[1]);
        push("p0_sq_later", 32'h0);   check(sq[1]);

        // back-to-back valid: payloads 0 and 2 accepted, 1 and 3 ignored
        cfg_valid  = 1'b1;
        cfg_enable = 1'b1;
        cfg_ch = 3'd3; cfg_period = CNT_W'(7);
        push("hs_ready0", 32'h1); check(cfg_ready);
        step(1);
        cfg_ch = 3'd3; cfg_period = CNT_W'(9);
        push("hs_ready1", 32'h0); check(cfg_ready);
        step(1);
        cfg_ch = 3'd3; cfg_period = CNT_W'(2);
        push("hs_ready2", 32'h1); check(cfg_ready);
        step(1);
        cfg_ch = 3'd3; cfg_period = CNT_W'(9);
        push("hs_ready3", 32'h0); check(cfg_ready);
        step(1);
        cfg_valid = 1'b0;
        push("hs_running", 32'h1); check(running[3]);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            push($sformatf("hs_tick_k%0d", k), (k % 2 == 0) ? 32'h1 : 32'h0);
            check(tick[3]);
        end

        // sync lands on ch0's terminal count; ch0 and ch2 restart phase
        write(3'd0, 4, 1'b1);
        write(3'd2, 6, 1'b1);
        step(1);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        push("sync_tick0", 32'h0);    check(tick[0]);
        push("sync_tick2", 32'h0);    check(tick[2]);
        push("sync_sq0", 32'h0);      check(sq[0]);
        push("sync_running", 32'h1);  check(running[0] & running[2]);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            push($sformatf("sync_tick0_k%0d", k), (k == 4) ? 32'h1 : 32'h0);
            check(tick[0]);
            push($sformatf("sync_tick2_k%0d", k), (k == 6) ? 32'h1 : 32'h0);
            check(tick[2]);
        end
        push("sync_sq0_after", 32'h1); check(sq[0]);

        // reset while a write to ch1 sits in APPLY
        cfg_valid  = 1'b1;
        cfg_ch     = 3'd1;
        cfg_period = CNT_W'(3);
        cfg_enable = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        push("rapply_ready", 32'h0); check(cfg_ready);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        push("rapply_tick", 32'h0);    check(tick);
        push("rapply_sq", 32'h0);      check(sq);
        push("rapply_running", 32'h0); check(running);
        push("rapply_ready1", 32'h1);  check(cfg_ready);
        step(5);
        push("rapply_running_later", 32'h0); check(running);
        push("rapply_tick_later", 32'h0);    check(tick);

        // out-of-range index must leave every channel as it was
        write(3'd0, 2, 1'b1);
        write(3'd5, 1, 1'b1);
        push("oor_ready", 32'h1);   check(cfg_ready);
        push("oor_running", 32'h1); check(running);
        push("oor_tick_a", 32'h1);  check(tick);
        push("oor_sq_a", 32'h1);    check(sq);
        step(1);
        push("oor_tick_b", 32'h0);  check(tick);
        push("oor_sq_b", 32'h1);    check(sq);
        step(1);
        push("oor_tick_c", 32'h1);  check(tick);
        push("oor_sq_c", 32'h0);    check(sq);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
